// File: rtl/shift_reg_test_sequencer.sv
// Sequences a socketed 74194 through a clear, all 256 {S,SR,SL,D} vectors and a final clear.
// Each chip clock is followed by a compare of the synchronised Q against a golden model.
module shift_reg_test_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int HIGH_CYCLES   = 2,
  parameter bit STOP_ON_FAIL  = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       DISP_RSLT,
  input  logic [3:0] Q_in,
  output logic       CLR_n,
  output logic       CHIP_CLK,
  output logic [1:0] S,
  output logic       SR,
  output logic       SL,
  output logic [3:0] D,
  output logic       Busy,
  output logic       Done,
  output logic       RSLT,
  output logic [8:0] Fail_Vec,
  output logic [3:0] State_dbg
);

  // Handshake: Run is a level sampled only in IDLE; Done/RSLT hold in DONE until
  // DISP_RSLT is sampled high, which returns to IDLE (Run is then ignored that cycle).
  typedef enum logic [3:0] {
    IDLE, CLR_LO, CLR_SET, CLR_CHK, VEC_SETUP, VEC_HIGH, VEC_SET, VEC_CHK, DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HIGH_LAST   = 8'(HIGH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  vec_q, vec_d;
  logic        final_q, final_d;
  logic        fail_q, fail_d;
  logic [8:0]  fail_vec_q, fail_vec_d;
  logic [3:0]  model_q, model_d;
  logic [3:0]  qs1_q, qs2_q;
  logic        mism;

  logic        clr_n_q, chip_clk_q, busy_q, done_q, rslt_q;
  logic [7:0]  drv_q, drv_d;

  function automatic logic [3:0] model_step(input logic [3:0] m, input logic [7:0] v);
    case (v[7:6])
      2'b00:   model_step = m;
      2'b01:   model_step = {m[2:0], v[5]};
      2'b10:   model_step = {v[4], m[3:1]};
      default: model_step = v[3:0];
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    vec_d      = vec_q;
    final_d    = final_q;
    fail_d     = fail_q;
    fail_vec_d = fail_vec_q;
    model_d    = model_q;
    mism       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (Run) begin
          state_d    = CLR_LO;
          fail_d     = 1'b0;
          fail_vec_d = '0;
          vec_d      = '0;
          final_d    = 1'b0;
        end
      end
      CLR_LO: begin
        model_d = '0;
        if (cnt_q == HIGH_LAST) begin
          state_d = CLR_SET;
          cnt_d   = '0;
        end
      end
      CLR_SET: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = CLR_CHK;
          cnt_d   = '0;
        end
      end
      CLR_CHK: begin
        cnt_d   = '0;
        mism    = (qs2_q != 4'h0);
        state_d = final_q ? DONE : VEC_SETUP;
      end
      VEC_SETUP: begin
        // Model advances on the same edge that raises CHIP_CLK.
        if (cnt_q == SETTLE_LAST) begin
          state_d = VEC_HIGH;
          cnt_d   = '0;
          model_d = model_step(model_q, vec_q);
        end
      end
      VEC_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          state_d = VEC_SET;
          cnt_d   = '0;
        end
      end
      VEC_SET: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = VEC_CHK;
          cnt_d   = '0;
        end
      end
      VEC_CHK: begin
        cnt_d = '0;
        mism  = (qs2_q != model_q);
        if (vec_q == 8'hFF) begin
          state_d = CLR_LO;
          final_d = 1'b1;
        end else begin
          state_d = VEC_SETUP;
          vec_d   = vec_q + 8'd1;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (DISP_RSLT) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Only the first failure is recorded.
    if (mism && !fail_q) begin
      fail_d = 1'b1;
      if (state_q == CLR_CHK) fail_vec_d = final_q ? 9'h1FF : 9'h100;
      else                    fail_vec_d = {1'b0, vec_q};
      if (STOP_ON_FAIL) state_d = DONE;
    end
  end

  always_comb begin
    drv_d = '0;
    if (state_d == VEC_SETUP || state_d == VEC_HIGH || state_d == VEC_SET || state_d == VEC_CHK)
      drv_d = vec_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      vec_q      <= '0;
      final_q    <= 1'b0;
      fail_q     <= 1'b0;
      fail_vec_q <= '0;
      model_q    <= '0;
      qs1_q      <= '0;
      qs2_q      <= '0;
      clr_n_q    <= 1'b1;
      chip_clk_q <= 1'b0;
      drv_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rslt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      final_q    <= final_d;
      fail_q     <= fail_d;
      fail_vec_q <= fail_vec_d;
      model_q    <= model_d;
      qs1_q      <= Q_in;
      qs2_q      <= qs1_q;
      // Pin drivers are registered off the next state so the chip sees glitch-free edges.
      clr_n_q    <= (state_d != CLR_LO);
      chip_clk_q <= (state_d == VEC_HIGH);
      drv_q      <= drv_d;
      busy_q     <= (state_d != IDLE) && (state_d != DONE);
      done_q     <= (state_d == DONE);
      rslt_q     <= (state_d == DONE) && !fail_d;
    end
  end

  assign CLR_n     = clr_n_q;
  assign CHIP_CLK  = chip_clk_q;
  assign S         = drv_q[7:6];
  assign SR        = drv_q[5];
  assign SL        = drv_q[4];
  assign D         = drv_q[3:0];
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign RSLT      = rslt_q;
  assign Fail_Vec  = fail_vec_q;
  assign State_dbg = state_q;

endmodule
